// File: rtl/keypad_decoder.sv
// Receive side of a 4x4 matrix keypad: accumulates one scan frame per row sweep
// and turns single-key frames into debounced press/hold/release events.
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned RELEASE_FRAMES  = 2
) (
  input  logic       keypad_clk,
  input  logic       reset,
  input  logic [3:0] keypad_row,
  input  logic [3:0] keypad_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } result_t;

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_FRAMES);
  localparam logic [3:0] REL_LIMIT = 4'(RELEASE_FRAMES);

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] col);
    return 3'(!col[0]) + 3'(!col[1]) + 3'(!col[2]) + 3'(!col[3]);
  endfunction

  state_t     state_r;
  logic [3:0] cand_r;
  logic [3:0] cnt_r;
  logic [3:0] rel_cnt_r;
  logic       acc_hit_r;
  logic       acc_multi_r;
  logic [3:0] acc_code_r;

  logic       row_valid_s;
  logic [1:0] row_idx_s;
  logic [1:0] col_idx_s;
  logic [2:0] low_cnt_s;
  logic       sample_hit_s;
  logic       frame_multi_s;
  logic       frame_hit_s;
  logic [3:0] frame_code_s;
  logic       frame_end_s;
  result_t    result_s;

  // Decode the current sample and fold it into the running frame result.
  always_comb begin
    row_valid_s = 1'b1;
    row_idx_s   = 2'd0;
    col_idx_s   = 2'd0;
    case (keypad_row)
      4'b1110: row_idx_s = 2'd0;
      4'b1101: row_idx_s = 2'd1;
      4'b1011: row_idx_s = 2'd2;
      4'b0111: row_idx_s = 2'd3;
      default: row_valid_s = 1'b0;
    endcase
    case (keypad_col)
      4'b1110: col_idx_s = 2'd0;
      4'b1101: col_idx_s = 2'd1;
      4'b1011: col_idx_s = 2'd2;
      4'b0111: col_idx_s = 2'd3;
      default: col_idx_s = 2'd0;
    endcase
    low_cnt_s    = low_count(keypad_col);
    sample_hit_s = row_valid_s && (low_cnt_s == 3'd1);
    // A bad row strobe, several low columns or a second hit all poison the frame.
    frame_multi_s = acc_multi_r || !row_valid_s || (low_cnt_s >= 3'd2) ||
                    (sample_hit_s && acc_hit_r);
    frame_hit_s   = acc_hit_r || sample_hit_s;
    if (acc_hit_r) begin
      frame_code_s = acc_code_r;
    end else begin
      frame_code_s = {row_idx_s, col_idx_s};
    end
    frame_end_s = (keypad_row == 4'b0111);
    if (frame_multi_s) begin
      result_s = RES_MULTI;
    end else if (frame_hit_s) begin
      result_s = RES_SINGLE;
    end else begin
      result_s = RES_NONE;
    end
  end

  // Frame accumulator, cleared on the frame-end sample that consumes it.
  always_ff @(posedge keypad_clk or negedge reset) begin
    if (!reset) begin
      acc_hit_r   <= 1'b0;
      acc_multi_r <= 1'b0;
      acc_code_r  <= 4'd0;
    end else if (frame_end_s) begin
      acc_hit_r   <= 1'b0;
      acc_multi_r <= 1'b0;
      acc_code_r  <= 4'd0;
    end else begin
      acc_hit_r   <= frame_hit_s;
      acc_multi_r <= frame_multi_s;
      acc_code_r  <= frame_code_s;
    end
  end

  // Debounce/press/release FSM with registered outputs, stepped once per frame.
  always_ff @(posedge keypad_clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cand_r    <= 4'd0;
      cnt_r     <= 4'd0;
      rel_cnt_r <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end_s) begin
        multi_key <= (result_s == RES_MULTI);
        case (state_r)
          IDLE: begin
            if (result_s == RES_SINGLE) begin
              cand_r  <= frame_code_s;
              cnt_r   <= 4'd1;
              state_r <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (result_s == RES_SINGLE && frame_code_s == cand_r) begin
              if (sat_inc(cnt_r) == DEB_LIMIT) begin
                key_code  <= cand_r;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rel_cnt_r <= 4'd0;
                cnt_r     <= 4'd0;
                state_r   <= PRESSED;
              end else begin
                cnt_r <= sat_inc(cnt_r);
              end
            end else if (result_s == RES_SINGLE) begin
              cand_r <= frame_code_s;
              cnt_r  <= 4'd1;
            end else begin
              cnt_r   <= 4'd0;
              state_r <= IDLE;
            end
          end
          PRESSED: begin
            // Rollover keys only restart the release count; no new event until release.
            if (result_s == RES_NONE) begin
              if (sat_inc(rel_cnt_r) == REL_LIMIT) begin
                key_held  <= 1'b0;
                rel_cnt_r <= 4'd0;
                state_r   <= IDLE;
              end else begin
                rel_cnt_r <= sat_inc(rel_cnt_r);
              end
            end else begin
              rel_cnt_r <= 4'd0;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed frame-level bench for keypad_decoder: table of scan frames with
// expected outputs after each frame end, plus a hand-written reset sequence.
module tb_keypad_decoder;

  logic       keypad_clk;
  logic       reset;
  logic [3:0] keypad_row;
  logic [3:0] keypad_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] keys;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_held;
    logic        exp_multi;
  } vec_t;

  vec_t vecs[$];

  keypad_decoder #(.DEBOUNCE_FRAMES(3), .RELEASE_FRAMES(2)) dut (
    .keypad_clk (keypad_clk),
    .reset      (reset),
    .keypad_row (keypad_row),
    .keypad_col (keypad_col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .multi_key  (multi_key)
  );

  initial keypad_clk = 1'b0;
  always #5 keypad_clk = ~keypad_clk;

  function automatic vec_t mk(input logic [15:0] k, input logic v, input logic [3:0] c,
                              input logic h, input logic m);
    vec_t r;
    r.keys = k; r.exp_valid = v; r.exp_code = c; r.exp_held = h; r.exp_multi = m;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s frame=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one full row sweep; keys bit r*4+c means row r / column c pressed.
  // Entered just after a negedge, returns just after a negedge.
  task automatic run_frame(input int idx, input vec_t v);
    logic [3:0] row_one;
    logic [3:0] col_keys;
    for (int r = 0; r < 4; r++) begin
      row_one    = 4'b0001 << r;
      col_keys   = v.keys[r*4 +: 4];
      keypad_row = ~row_one;
      keypad_col = ~col_keys;
      @(posedge keypad_clk);
      #1;
      if (r < 3) begin
        check("valid_mid_frame", idx, {3'd0, key_valid}, 4'd0);
      end else begin
        check("key_valid", idx, {3'd0, key_valid}, {3'd0, v.exp_valid});
        check("key_code",  idx, key_code, v.exp_code);
        check("key_held",  idx, {3'd0, key_held}, {3'd0, v.exp_held});
        check("multi_key", idx, {3'd0, multi_key}, {3'd0, v.exp_multi});
      end
      @(negedge keypad_clk);
    end
  endtask

  task automatic check_all_zero(input int idx);
    check("rst_key_code",  idx, key_code, 4'd0);
    check("rst_key_valid", idx, {3'd0, key_valid}, 4'd0);
    check("rst_key_held",  idx, {3'd0, key_held}, 4'd0);
    check("rst_multi_key", idx, {3'd0, multi_key}, 4'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    keypad_row = 4'b1110;
    keypad_col = 4'b1111;

    // Press key 6 (row1/col2): valid at end of frame 3, then 2-frame release.
    vecs.push_back(mk(16'h0040, 1'b0, 4'd0,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b0, 4'd0,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b1, 4'd6,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b0, 1'b0));
    // Bounce: 2 present, 1 absent, 3 present.
    vecs.push_back(mk(16'h0040, 1'b0, 4'd6,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b0, 4'd6,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b0, 4'd6,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b0, 4'd6,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b1, 4'd6,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b0, 1'b0));
    // Multi: col=1001 on row 0 for 5 frames, then two keys in different rows.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(16'h0006, 1'b0, 4'd6, 1'b0, 1'b1));
    vecs.push_back(mk(16'h0041, 1'b0, 4'd6,  1'b0, 1'b1));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b0, 1'b0));
    // Rollover: key 15, add key 0, release both, then key 0.
    vecs.push_back(mk(16'h8000, 1'b0, 4'd6,  1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, 1'b0, 4'd6,  1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, 1'b1, 4'd15, 1'b1, 1'b0));
    vecs.push_back(mk(16'h8001, 1'b0, 4'd15, 1'b1, 1'b1));
    vecs.push_back(mk(16'h8001, 1'b0, 4'd15, 1'b1, 1'b1));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd15, 1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd15, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0001, 1'b0, 4'd15, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0001, 1'b0, 4'd15, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0001, 1'b1, 4'd0,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd0,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd0,  1'b0, 1'b0));
    // Leave key_code at 6 so the reset check below sees it cleared.
    vecs.push_back(mk(16'h0040, 1'b0, 4'd0,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b0, 4'd0,  1'b0, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b1, 4'd6,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b1, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 4'd6,  1'b0, 1'b0));

    repeat (2) @(negedge keypad_clk);
    #1;
    check_all_zero(0);
    @(negedge keypad_clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(i + 1, vecs[i]);
    end

    // Reset mid-debounce: two good frames, reset pulse, then a fresh 3-frame press.
    run_frame(100, mk(16'h0040, 1'b0, 4'd6, 1'b0, 1'b0));
    run_frame(101, mk(16'h0040, 1'b0, 4'd6, 1'b0, 1'b0));
    reset = 1'b0;
    #1;
    check_all_zero(102);
    @(negedge keypad_clk);
    reset = 1'b1;
    run_frame(103, mk(16'h0040, 1'b0, 4'd0, 1'b0, 1'b0));
    run_frame(104, mk(16'h0040, 1'b0, 4'd0, 1'b0, 1'b0));
    run_frame(105, mk(16'h0040, 1'b1, 4'd6, 1'b1, 1'b0));
    run_frame(106, mk(16'h0000, 1'b0, 4'd6, 1'b1, 1'b0));
    run_frame(107, mk(16'h0000, 1'b0, 4'd6, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
